// File: rtl/vedic_multiplier_project.sv
// Registered 8x8 unsigned Urdhva-Tiryagbhyam multiplier: p = a*b, one cycle latency.
// The core is built hierarchically from 2x2 cells, with exact-width adders at each level.
module vedic_multiplier_project (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  localparam int unsigned PW = 16;

  logic [PW-1:0] prod_c;

  // 2x2 cell: four partial products reduced with two half adders
  function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
    logic pp00, pp01, pp10, pp11;
    logic s1, c1;
    pp00 = x[0] & y[0];
    pp01 = x[0] & y[1];
    pp10 = x[1] & y[0];
    pp11 = x[1] & y[1];
    s1   = pp10 ^ pp01;
    c1   = pp10 & pp01;
    return {pp11 & c1, pp11 ^ c1, s1, pp00};
  endfunction

  // 4x4 cell: cross terms summed at offset 2, high term at offset 4
  function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] q0, q1, q2, q3, hi;
    logic [4:0] mid;
    q0  = mul2(x[1:0], y[1:0]);
    q1  = mul2(x[3:2], y[1:0]);
    q2  = mul2(x[1:0], y[3:2]);
    q3  = mul2(x[3:2], y[3:2]);
    mid = 5'(q1) + 5'(q2) + 5'(q0[3:2]);
    hi  = q3 + 4'(mid[4:2]);
    return {hi, mid[1:0], q0[1:0]};
  endfunction

  // 8x8 cell: same structure as 4x4, offsets 4 and 8
  function automatic logic [15:0] mul8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] q0, q1, q2, q3, hi;
    logic [8:0] mid;
    q0  = mul4(x[3:0], y[3:0]);
    q1  = mul4(x[7:4], y[3:0]);
    q2  = mul4(x[3:0], y[7:4]);
    q3  = mul4(x[7:4], y[7:4]);
    mid = 9'(q1) + 9'(q2) + 9'(q0[7:4]);
    hi  = q3 + 8'(mid[8:4]);
    return {hi, mid[3:0], q0[3:0]};
  endfunction

  always_comb begin
    prod_c = mul8(a, b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
    end else begin
      p <= prod_c;
    end
  end

endmodule

// File: tb/tb_vedic_multiplier_project.sv
// Scoreboard bench for vedic_multiplier_project: stimulus pushes a*b, a monitor pops
// one expectation per rising edge and compares it against p.
module tb_vedic_multiplier_project;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  a = 8'h00;
  logic [7:0]  b = 8'h00;
  logic [15:0] p;

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  vedic_multiplier_project dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .p    (p)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Drive one operand pair at the falling edge; its product is due after the next rising edge
  task automatic drive(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    a = x;
    b = y;
    exp_q.push_back(16'(x) * 16'(y));
  endtask

  // Monitor: one product per rising edge while out of reset
  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1 && exp_q.size() != 0) begin
      check("product", p, exp_q.pop_front());
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] dir_a[5]  = '{8'd15, 8'd255, 8'd100, 8'd0,   8'd1};
    logic [7:0] dir_b[5]  = '{8'd10, 8'd255, 8'd25,  8'd123, 8'd200};
    logic [7:0] thr_a[4]  = '{8'd3,  8'd16,  8'd128, 8'd200};
    logic [7:0] thr_b[4]  = '{8'd7,  8'd16,  8'd2,   8'd200};
    logic [7:0] cor_a[5]  = '{8'd0,  8'd255, 8'd1,   8'd128, 8'd255};
    logic [7:0] cor_b[5]  = '{8'd0,  8'd1,   8'd255, 8'd128, 8'd254};

    // Reset held with maximal operands while clocking
    rst_n = 1'b0;
    a = 8'hFF;
    b = 8'hFF;
    repeat (4) begin
      @(posedge clk);
      #2;
      check("reset_hold", p, 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(16'd65025);

    // Directed values, each held for two cycles
    for (int i = 0; i < 5; i++) begin
      drive(dir_a[i], dir_b[i]);
      drive(dir_a[i], dir_b[i]);
    end

    // Back-to-back operand changes
    for (int i = 0; i < 4; i++) drive(thr_a[i], thr_b[i]);

    // Asynchronous reset between edges while p = 65025
    drive(8'd255, 8'd255);
    @(posedge clk);
    #3;
    check("pre_reset", p, 16'd65025);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_clear", p, 16'h0000);
    repeat (2) begin
      @(posedge clk);
      #2;
      check("reset_hold_mid", p, 16'h0000);
    end
    @(negedge clk);
    a = 8'd12;
    b = 8'd12;
    rst_n = 1'b1;
    exp_q.push_back(16'd144);

    // Corners, then random pairs
    for (int i = 0; i < 5; i++) drive(cor_a[i], cor_b[i]);
    repeat (300) drive(8'($urandom), 8'($urandom));

    // Exhaustive sweep, one pair per cycle
    for (int i = 0; i < 65536; i++) drive(8'(i >> 8), 8'(i));

    // Bounded drain of outstanding expectations
    for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    check("drain_pending", 16'(exp_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vedic_multiplier_project.md
# vedic_multiplier_project

Registered 8x8 unsigned multiplier built as a Vedic (Urdhva-Tiryagbhyam) array. It takes two 8-bit operands each clock and presents their 16-bit product on a registered output one cycle later. It is the top-level datapath block of the multiplier ASIC flow and is instantiated as `project`. It has no handshake: it accepts a new operand pair on every clock.

## Interface

- No parameters. Widths are fixed at 8x8 -> 16.
- clk  input  1  System clock. All state updates on the rising edge.
- rst_n  input  1  Asynchronous, active-low reset. Asserting it clears the output register immediately. Deassertion is synchronous to clk at the system level.
- a  input  8  Multiplicand, unsigned.
- b  input  8  Multiplier, unsigned.
- p  output  16  Registered product, unsigned: p = a*b.

## Operation

- Arithmetic is fully unsigned. The product is exact and never truncated; the 16-bit range covers the maximum 255*255 = 65025 (0xFE01).
- The combinational core is hierarchical Vedic:
  - 2x2 cell: the four partial products a[i]&b[j] are combined with two half adders, giving a 4-bit result.
  - 4x4 cell: four 2x2 cells (aL*bL, aH*bL, aL*bH, aH*bH) feed the adder stage.
    - Low 2 bits of aL*bL pass straight through.
    - The remaining bits are summed by ripple/carry adders at offsets 2 and 4, giving an 8-bit result.
  - 8x8 cell: four 4x4 cells combined with the same structure at offsets 4 and 8, giving a 16-bit result.
- All intermediate adders are sized so that no carry is dropped. The 8x8 core result must equal a*b for all 65536 input pairs.
- The output register p captures the core result on each rising clk edge when rst_n is high.
- The inputs a and b are not registered. They must be stable for setup time before the rising edge.
- There is no enable, valid, or ready signal. Every clock edge samples the inputs.

## Timing

- Latency is 1 cycle: p after rising edge k equals a*b as sampled at edge k.
- Throughput is one product per cycle. Back-to-back operand changes produce back-to-back results with no bubbles.
- Reset value: p = 16'h0000.
  - p clears asynchronously on the falling edge of rst_n, without waiting for clk.
  - While rst_n is low, p holds 0 regardless of clk, a, or b.
- On the first rising edge after rst_n rises, p loads a*b of the inputs present at that edge.
- Reset asserted mid-stream: the product in flight is discarded and p reads 0. No stale value reappears after release.
- Inputs changing between edges (for example at the falling edge) do not affect p until the next rising edge. p is glitch-free because it is driven only by the register.
- X on a or b: p becomes X at the next edge only. Reset clears it.

## Test plan

- Reset: hold rst_n=0 with a=8'hFF, b=8'hFF and toggle clk -> p stays 0. Release rst_n, then at the next rising edge -> p = 65025.
- Directed sequence, with inputs changed at the falling edge and held 2 cycles each: 15x10 -> 150; 255x255 -> 65025; 100x25 -> 2500; 0x123 -> 0; 1x200 -> 200. Each value must appear on p one rising edge after it is sampled and hold while the inputs hold.
- Latency and throughput: change a/b every cycle (3x7, 16x16, 128x2, 200x200) -> p = 21, 256, 256, 40000 on consecutive edges, each one cycle after sampling.
- Asynchronous reset mid-operation: with p = 65025, pull rst_n low between clock edges -> p = 0 immediately. Release rst_n with a=12, b=12 -> p = 144 at the next edge.
- Exhaustive: all 65536 (a,b) pairs, one per cycle, compared against a reference a*b with 1-cycle delay -> zero mismatches. Include corners 0x0, 255x1, 1x255, 128x128 = 16384, and 255x254 = 64770.
